surf_dna_reader: RTL and testbench

Wishbone initiator that walks the SURF ID/control register block after a start request: reads the DEVICE and VERSION words, issues the DNA load write, then reads the DNA register 96 times to assemble the device DNA. It sits on the internal wb bus as a bus master beside the housekeeping path. It presents the identity words and DNA as static outputs for the TURF link and status logic.

---
 rtl/surf_dna_reader_pkg.sv | 23 ++
 rtl/surf_dna_reader_initiator.sv | 78 +++++++
 rtl/surf_dna_reader.sv | 165 ++++++++++++++++
 tb/tb_surf_dna_reader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/surf_dna_reader_pkg.sv
// Shared types and constants for the SURF identity/DNA reader.
package surf_dna_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_DEVICE,
        RD_VERSION,
        WR_LOAD,
        RD_DNA,
        DONE,
        ERROR
    } state_t;

    localparam logic [11:0] ID_DEVICE_OFS  = 12'h000;
    localparam logic [11:0] ID_VERSION_OFS = 12'h004;
    localparam logic [11:0] ID_DNA_OFS     = 12'h008;

    localparam int          DNA_BITS      = 96;
    localparam logic [6:0]  DNA_LAST_BIT  = 7'(DNA_BITS - 1);
    localparam logic [31:0] DNA_LOAD_WORD = 32'h8000_0000;
    localparam logic [3:0]  DNA_LOAD_SEL  = 4'b1000;

endpackage

// File: rtl/surf_dna_reader_initiator.sv
// Single-transaction wishbone issue/hold/gap engine.
// Optional ack timeout enabled by SURF_DNA_READER_TIMEOUT_EN.
module wb_single_initiator #(
    parameter int WB_ADR_BITS = 11,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [WB_ADR_BITS-1:0] adr,
    input  logic                   we,
    input  logic [31:0]            dat,
    input  logic [3:0]             sel,
    output logic                   done,
    output logic                   ok,
    output logic                   retry,
    output logic                   fail,
    output logic [31:0]            rdata,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [WB_ADR_BITS-1:0] wb_adr_o,
    output logic [31:0]            wb_dat_o,
    output logic [3:0]             wb_sel_o,
    input  logic [31:0]            wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i
);

    logic term;
    logic tmo_hit;

    assign term = wb_ack_i | wb_err_i | wb_rty_i;

`ifdef SURF_DNA_READER_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || !wb_stb_o) begin
            tmo_cnt <= 8'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign tmo_hit = wb_stb_o && !term && (tmo_cnt == 8'(TIMEOUT));
`else
    assign tmo_hit = 1'b0;
`endif

    assign done  = wb_stb_o & (term | tmo_hit);
    assign fail  = wb_stb_o & (wb_err_i | tmo_hit);
    assign retry = wb_stb_o & wb_rty_i & ~wb_err_i;
    assign ok    = wb_stb_o & wb_ack_i & ~wb_err_i;
    assign rdata = wb_dat_i;

    // Dropping the strobe on the termination edge and only issuing from the
    // idle side guarantees at least one cyc=0 cycle between transactions.
    always_ff @(posedge clk) begin
        if (rst || (wb_stb_o && done)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
        end else if (!wb_stb_o && req) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= we;
            wb_adr_o <= adr;
            wb_dat_o <= dat;
            wb_sel_o <= sel;
        end
    end

endmodule

// File: rtl/surf_dna_reader.sv
// Wishbone initiator that reads DEVICE/VERSION and assembles the 96-bit DNA.
// Define SURF_DNA_READER_TIMEOUT_EN to abort on a missing termination.
module surf_dna_reader
    import surf_dna_reader_pkg::*;
#(
    parameter int                   WB_ADR_BITS   = 11,
    parameter logic [WB_ADR_BITS-1:0] BASE_ADR    = '0,
    parameter int                   TIMEOUT       = 255,
    parameter logic [31:0]          EXPECT_DEVICE = "SURF"
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [WB_ADR_BITS-1:0] wb_adr_o,
    output logic [31:0]            wb_dat_o,
    output logic [3:0]             wb_sel_o,
    input  logic [31:0]            wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic                   err_o,
    output logic [31:0]            device_o,
    output logic [31:0]            version_o,
    output logic [95:0]            dna_o
);

    state_t                 state;
    logic [6:0]             bit_cnt;
    logic                   req;
    logic                   we;
    logic [WB_ADR_BITS-1:0] adr;
    logic [31:0]            dat;
    logic [3:0]             sel;
    logic                   done;
    logic                   ok;
    logic                   retry;
    logic                   fail;
    logic [31:0]            rdata;

    always_comb begin
        req = 1'b0;
        we  = 1'b0;
        adr = BASE_ADR;
        dat = '0;
        sel = 4'hF;
        case (state)
            RD_DEVICE: begin
                req = 1'b1;
                adr = BASE_ADR + WB_ADR_BITS'(ID_DEVICE_OFS);
            end
            RD_VERSION: begin
                req = 1'b1;
                adr = BASE_ADR + WB_ADR_BITS'(ID_VERSION_OFS);
            end
            WR_LOAD: begin
                req = 1'b1;
                we  = 1'b1;
                adr = BASE_ADR + WB_ADR_BITS'(ID_DNA_OFS);
                dat = DNA_LOAD_WORD;
                sel = DNA_LOAD_SEL;
            end
            RD_DNA: begin
                req = 1'b1;
                adr = BASE_ADR + WB_ADR_BITS'(ID_DNA_OFS);
            end
            default: ;
        endcase
    end

    wb_single_initiator #(
        .WB_ADR_BITS(WB_ADR_BITS),
        .TIMEOUT    (TIMEOUT)
    ) u_init (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .req      (req),
        .adr      (adr),
        .we       (we),
        .dat      (dat),
        .sel      (sel),
        .done     (done),
        .ok       (ok),
        .retry    (retry),
        .fail     (fail),
        .rdata    (rdata),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i)
    );

    // A retried transaction leaves state and bit_cnt alone, so the engine
    // reissues the same request after its gap; err outranks rty outranks ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            bit_cnt   <= 7'd0;
            busy_o    <= 1'b0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            device_o  <= '0;
            version_o <= '0;
            dna_o     <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_i) begin
                        state   <= RD_DEVICE;
                        busy_o  <= 1'b1;
                        valid_o <= 1'b0;
                        err_o   <= 1'b0;
                        dna_o   <= '0;
                        bit_cnt <= 7'd0;
                    end
                end
                default: begin
                    if (done && fail) begin
                        state  <= ERROR;
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                    end else if (done && ok && !retry) begin
                        case (state)
                            RD_DEVICE: begin
                                device_o <= rdata;
                                state    <= RD_VERSION;
                            end
                            RD_VERSION: begin
                                version_o <= rdata;
                                state     <= WR_LOAD;
                            end
                            WR_LOAD: state <= RD_DNA;
                            RD_DNA: begin
                                dna_o[bit_cnt] <= rdata[0];
                                if (bit_cnt == DNA_LAST_BIT) begin
                                    state  <= DONE;
                                    busy_o <= 1'b0;
                                    if (device_o == EXPECT_DEVICE) begin
                                        valid_o <= 1'b1;
                                    end else begin
                                        err_o <= 1'b1;
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 7'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_surf_dna_reader.sv
// Directed bench for surf_dna_reader with an ID-block responder and a result scoreboard.
// Build with SURF_DNA_READER_TIMEOUT_EN to exercise the ack timeout path.
module tb_surf_dna_reader;

    localparam logic [31:0] SURF_WORD = 32'h5355_5246;
    localparam logic [31:0] TURF_WORD = 32'h5455_5246;
    localparam logic [31:0] VER_WORD  = 32'h0001_0203;
    localparam logic [95:0] DNA_WORD  = 96'hA5A5_1234_5678_9ABC_DEF0_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc, wb_stb, wb_we;
    logic [10:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        wb_rty = 1'b0;
    logic        start = 1'b0;
    logic        busy, valid, err;
    logic [31:0] device, version;
    logic [95:0] dna;

    surf_dna_reader dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_cyc_o (wb_cyc),
        .wb_stb_o (wb_stb),
        .wb_we_o  (wb_we),
        .wb_adr_o (wb_adr),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack),
        .wb_err_i (wb_err),
        .wb_rty_i (wb_rty),
        .start_i  (start),
        .busy_o   (busy),
        .valid_o  (valid),
        .err_o    (err),
        .device_o (device),
        .version_o(version),
        .dna_o    (dna)
    );

    initial forever #5 clk = ~clk;

    // Responder configuration, written only by the stimulus block
    logic [31:0] dev_word = SURF_WORD;
    int          err_at   = -1;
    int          rty_cfg  = 0;
    bit          silent   = 1'b0;

    int dna_idx  = 0;
    int rty_used = 0;

    // ID block model: one-cycle registered termination, never back-to-back
    always @(posedge clk) begin
        wb_ack   <= 1'b0;
        wb_err   <= 1'b0;
        wb_rty   <= 1'b0;
        wb_dat_i <= '0;
        if (start && !busy) rty_used <= 0;
        if (wb_cyc && wb_stb && !wb_ack && !wb_err && !wb_rty) begin
            case (wb_adr)
                11'h000: begin
                    wb_ack   <= 1'b1;
                    wb_dat_i <= dev_word;
                end
                11'h004: begin
                    if (silent) begin
                    end else if (rty_used < rty_cfg) begin
                        wb_rty   <= 1'b1;
                        rty_used <= rty_used + 1;
                    end else begin
                        wb_ack   <= 1'b1;
                        wb_dat_i <= VER_WORD;
                    end
                end
                11'h008: begin
                    if (wb_we) begin
                        wb_ack  <= 1'b1;
                        dna_idx <= 0;
                    end else if (dna_idx == err_at) begin
                        wb_err <= 1'b1;
                    end else begin
                        wb_ack   <= 1'b1;
                        wb_dat_i <= {31'b0, DNA_WORD[dna_idx]};
                        dna_idx  <= dna_idx + 1;
                    end
                end
                default: wb_err <= 1'b1;
            endcase
        end
    end

    // Bus monitor: issue counts, write contents, strobe release/gap, strobe length
    int trans_total = 0, write_total = 0, bad_write_total = 0;
    int ver_total = 0, dna_rd_total = 0, gap_viol_total = 0;
    int stb_run = 0, last_stb_run = 0;
    bit prev_stb = 1'b0, prev_term = 1'b0;

    always @(negedge clk) begin
        if (wb_stb && !prev_stb) begin
            trans_total++;
            if (wb_we) begin
                write_total++;
                if (wb_adr != 11'h008 || wb_dat_o != 32'h8000_0000 || wb_sel != 4'b1000)
                    bad_write_total++;
            end else if (wb_adr == 11'h004) begin
                ver_total++;
            end else if (wb_adr == 11'h008) begin
                dna_rd_total++;
            end
        end
        if (prev_term && wb_cyc) gap_viol_total++;
        prev_term = wb_stb && (wb_ack || wb_err || wb_rty);
        if (wb_stb) begin
            stb_run++;
        end else if (stb_run != 0) begin
            last_stb_run = stb_run;
            stb_run = 0;
        end
        prev_stb = wb_stb;
    end

    typedef struct {
        logic [31:0] device;
        logic [31:0] version;
        logic [95:0] dna;
        logic        valid;
        logic        err;
        int          trans;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int trans_base, write_base, bad_write_base, ver_base, dna_rd_base, gap_base;
    int run_cycles;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snapshot();
        trans_base     = trans_total;
        write_base     = write_total;
        bad_write_base = bad_write_total;
        ver_base       = ver_total;
        dna_rd_base    = dna_rd_total;
        gap_base       = gap_viol_total;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start a sequence and wait (bounded) for busy to fall; optional stray start mid-run
    task automatic applyStimulus(input bit mid_pulse);
        int n;
        snapshot();
        pulseStart();
        n = 1;
        while (busy && n < 3000) begin
            start = (mid_pulse && n == 100);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        run_cycles = n;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        check({tag, ".sb_size"}, 96'(sb.size()), 96'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".device"},  device, e.device);
            check({tag, ".version"}, version, e.version);
            check({tag, ".dna"},     dna, e.dna);
            check({tag, ".valid"},   valid, e.valid);
            check({tag, ".err"},     err, e.err);
            check({tag, ".busy"},    busy, 1'b0);
            check({tag, ".trans"},   96'(trans_total - trans_base), 96'(e.trans));
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".cyc"},     wb_cyc, 1'b0);
        check({tag, ".stb"},     wb_stb, 1'b0);
        check({tag, ".we"},      wb_we, 1'b0);
        check({tag, ".adr"},     wb_adr, 11'h0);
        check({tag, ".dat"},     wb_dat_o, 32'h0);
        check({tag, ".sel"},     wb_sel, 4'h0);
        check({tag, ".busy"},    busy, 1'b0);
        check({tag, ".valid"},   valid, 1'b0);
        check({tag, ".err"},     err, 1'b0);
        check({tag, ".device"},  device, 32'h0);
        check({tag, ".version"}, version, 32'h0);
        check({tag, ".dna"},     dna, 96'h0);
    endtask

    initial begin
        logic [95:0] low40;
        int          waited;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] nominal sequence with stray start mid-run");
        sb.push_back('{SURF_WORD, VER_WORD, DNA_WORD, 1'b1, 1'b0, 99});
        applyStimulus(1'b1);
        checkOutput("nominal");
        check("nominal.busy_window", 96'(run_cycles >= 297 && run_cycles <= 299), 96'd1);
        check("nominal.writes", 96'(write_total - write_base), 96'd1);
        check("nominal.bad_writes", 96'(bad_write_total - bad_write_base), 96'd0);
        check("nominal.gap_viol", 96'(gap_viol_total - gap_base), 96'd0);
        check("nominal.dna_reads", 96'(dna_rd_total - dna_rd_base), 96'd96);

        $display("[TB] DEVICE mismatch");
        dev_word = TURF_WORD;
        sb.push_back('{TURF_WORD, VER_WORD, DNA_WORD, 1'b0, 1'b1, 99});
        applyStimulus(1'b0);
        checkOutput("turf");
        dev_word = SURF_WORD;

        $display("[TB] bus error on DNA read 40");
        err_at = 40;
        low40  = DNA_WORD & ((96'd1 << 40) - 96'd1);
        sb.push_back('{SURF_WORD, VER_WORD, low40, 1'b0, 1'b1, 44});
        applyStimulus(1'b0);
        checkOutput("buserr");
        repeat (20) @(negedge clk);
        check("buserr.no_more_trans", 96'(trans_total - trans_base), 96'd44);
        check("buserr.cyc_idle", wb_cyc, 1'b0);
        err_at = -1;

        $display("[TB] two retries on VERSION");
        rty_cfg = 2;
        sb.push_back('{SURF_WORD, VER_WORD, DNA_WORD, 1'b1, 1'b0, 101});
        applyStimulus(1'b0);
        checkOutput("retry");
        check("retry.ver_issues", 96'(ver_total - ver_base), 96'd3);
        check("retry.gap_viol", 96'(gap_viol_total - gap_base), 96'd0);
        rty_cfg = 0;

        $display("[TB] silent target on VERSION");
        silent = 1'b1;
`ifdef SURF_DNA_READER_TIMEOUT_EN
        sb.push_back('{SURF_WORD, VER_WORD, 96'h0, 1'b0, 1'b1, 2});
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("timeout");
        check("timeout.stb_len", 96'(last_stb_run >= 255 && last_stb_run <= 257), 96'd1);
        check("timeout.cyc_idle", wb_cyc, 1'b0);
`else
        pulseStart();
        repeat (1000) @(negedge clk);
        check("silent.stb_held", wb_stb, 1'b1);
        check("silent.busy_held", busy, 1'b1);
`endif
        silent = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset during DNA read 50, then restart");
        snapshot();
        pulseStart();
        waited = 0;
        while ((dna_rd_total - dna_rd_base) < 51 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("midrst.reached_read50", 96'((dna_rd_total - dna_rd_base) >= 51), 96'd1);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midrst");
        rst = 1'b0;
        @(negedge clk);
        sb.push_back('{SURF_WORD, VER_WORD, DNA_WORD, 1'b1, 1'b0, 99});
        applyStimulus(1'b0);
        checkOutput("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
